// File: rtl/branch_resolve_unit.sv
// Registered branch resolution stage: evaluates the RISC-V branch condition on rs1/rs2,
// computes target and redirect PC, flags mispredicts and keeps saturating performance counters.
module branch_resolve_unit #(
    parameter int XLEN       = 32,
    parameter int CNT_W      = 16,
    parameter int ILEN_BYTES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       funct3,
    input  logic [XLEN-1:0]  rs1,
    input  logic [XLEN-1:0]  rs2,
    input  logic [XLEN-1:0]  pc,
    input  logic [XLEN-1:0]  imm,
    input  logic             pred_taken,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_taken,
    output logic [XLEN-1:0]  out_target,
    output logic             out_mispredict,
    output logic [XLEN-1:0]  out_redirect_pc,
    output logic             out_illegal,
    input  logic             cnt_clear,
    output logic [CNT_W-1:0] cnt_branches,
    output logic [CNT_W-1:0] cnt_mispredicts
);

    localparam int NUM_CNT = 2;

    logic             out_valid_reg;
    logic             out_taken_reg;
    logic [XLEN-1:0]  out_target_reg;
    logic             out_mispredict_reg;
    logic [XLEN-1:0]  out_redirect_pc_reg;
    logic             out_illegal_reg;

    logic             taken_next;
    logic             illegal_next;
    logic             mispredict_next;
    logic [XLEN-1:0]  target_next;
    logic [XLEN-1:0]  fall_through;
    logic [XLEN-1:0]  redirect_next;

    logic             eq;
    logic             lt_s;
    logic             lt_u;
    logic             capture;
    logic             handshake;

    logic [CNT_W-1:0] cnt_reg  [NUM_CNT];
    logic [CNT_W-1:0] cnt_next [NUM_CNT];
    logic             cnt_inc  [NUM_CNT];

    // Direct full-width comparisons; no ALU flags involved.
    assign eq   = (rs1 == rs2);
    assign lt_s = ($signed(rs1) < $signed(rs2));
    assign lt_u = (rs1 < rs2);

    always_comb begin
        taken_next   = 1'b0;
        illegal_next = 1'b0;
        case (funct3)
            3'b000:  taken_next = eq;
            3'b001:  taken_next = ~eq;
            3'b100:  taken_next = lt_s;
            3'b101:  taken_next = ~lt_s;
            3'b110:  taken_next = lt_u;
            3'b111:  taken_next = ~lt_u;
            default: illegal_next = 1'b1;
        endcase
    end

    // Address arithmetic wraps modulo 2^XLEN by construction.
    assign target_next     = pc + imm;
    assign fall_through    = pc + XLEN'(ILEN_BYTES);
    assign redirect_next   = taken_next ? target_next : fall_through;
    assign mispredict_next = ~illegal_next & (taken_next ^ pred_taken);

    assign in_ready  = ~out_valid_reg | out_ready;
    assign capture   = in_valid & in_ready & ~flush;
    assign handshake = out_valid_reg & out_ready & ~out_illegal_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_reg       <= 1'b0;
            out_taken_reg       <= 1'b0;
            out_target_reg      <= '0;
            out_mispredict_reg  <= 1'b0;
            out_redirect_pc_reg <= '0;
            out_illegal_reg     <= 1'b0;
        end else if (flush) begin
            out_valid_reg <= 1'b0;
        end else if (capture) begin
            out_valid_reg       <= 1'b1;
            out_taken_reg       <= taken_next;
            out_target_reg      <= target_next;
            out_mispredict_reg  <= mispredict_next;
            out_redirect_pc_reg <= redirect_next;
            out_illegal_reg     <= illegal_next;
        end else if (out_ready) begin
            out_valid_reg <= 1'b0;
        end
    end

    assign cnt_inc[0] = handshake;
    assign cnt_inc[1] = handshake & out_mispredict_reg;

    // Clear beats increment; increments stop at all-ones.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_CNT; gi++) begin : g_cnt
            assign cnt_next[gi] = cnt_clear ? '0 :
                                  (cnt_inc[gi] && (cnt_reg[gi] != {CNT_W{1'b1}})) ?
                                  cnt_reg[gi] + 1'b1 : cnt_reg[gi];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_reg[gi] <= '0;
                end else begin
                    cnt_reg[gi] <= cnt_next[gi];
                end
            end
        end
    endgenerate

    assign out_valid       = out_valid_reg;
    assign out_taken       = out_taken_reg;
    assign out_target      = out_target_reg;
    assign out_mispredict  = out_mispredict_reg;
    assign out_redirect_pc = out_redirect_pc_reg;
    assign out_illegal     = out_illegal_reg;
    assign cnt_branches    = cnt_reg[0];
    assign cnt_mispredicts = cnt_reg[1];

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Parametrised, registered branch resolution stage for the RV32/RV64 execute path.
- Compares rs1 and rs2 directly, evaluating all six RISC-V branch conditions, rather than consuming ALU flags.
- Computes the branch target and checks the front-end prediction, producing a redirect PC on mispredict.
- Sits between issue and the fetch redirect logic; valid/ready handshake on both sides; keeps saturating branch and mispredict counters.

Parameters:
- XLEN, 32, operand/PC width; legal values 32 or 64.
- CNT_W, 16, width of each performance counter.
- ILEN_BYTES, 4, fall-through increment added to pc.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  request valid.
- in_ready  output  1  unit can accept a request this cycle.
- funct3  input  3  branch condition code.
- rs1  input  XLEN  operand 1.
- rs2  input  XLEN  operand 2.
- pc  input  XLEN  branch instruction PC.
- imm  input  XLEN  sign-extended branch offset.
- pred_taken  input  1  front-end prediction.
- flush  input  1  kill the in-flight result and block capture.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- out_taken  output  1  resolved direction.
- out_target  output  XLEN  pc+imm.
- out_mispredict  output  1  out_taken != registered pred_taken; legal codes only.
- out_redirect_pc  output  XLEN  out_target if taken, else pc+ILEN_BYTES.
- out_illegal  output  1  funct3 is 010 or 011.
- cnt_clear  input  1  synchronous clear of both counters.
- cnt_branches  output  CNT_W  completed legal branches.
- cnt_mispredicts  output  CNT_W  completed mispredicted branches.

Behaviour:
- Reset (rst_n low, asynchronous): all outputs and counters go to 0, including out_valid and all result fields. in_ready is 1 immediately after reset.
- Conditions:
  - 000: eq
  - 001: ne
  - 100: signed rs1<rs2
  - 101: signed rs1>=rs2
  - 110: unsigned rs1<rs2
  - 111: unsigned rs1>=rs2
  - 010/011: taken=0, illegal=1, mispredict=0.
- Comparisons are full XLEN width, with no flag derivation. Signed means two's complement.
- Address arithmetic is modulo 2^XLEN; wrap-around is silent.
- Handshake:
  - Single output register; latency exactly 1 cycle.
  - in_ready = ~out_valid | out_ready.
  - Capture happens when in_valid & in_ready & ~flush.
  - Output fields hold stable while out_valid & ~out_ready.
- Output register update each cycle:
  - flush=1: out_valid goes to 0 next cycle; no capture; flush beats a simultaneous capture.
  - else capture: out_valid goes to 1 and fields load.
  - else out_ready: out_valid goes to 0.
  - else hold.
- Back-to-back throughput: one result per cycle when out_ready stays high.
- Counters:
  - Increment only on an output handshake (out_valid & out_ready) of a non-illegal result.
  - cnt_branches increments by 1; cnt_mispredicts increments by 1 when out_mispredict is set.
  - Both saturate at 2^CNT_W−1; no wrap.
  - cnt_clear wins over a simultaneous increment, giving 0.
  - flush does not affect the counters.
- A result killed by flush before handshake is never counted.
- Reset mid-operation drops the in-flight result; it is never counted and never presented.

Test Plan:
- Reset/idle: assert rst_n=0 mid-cycle with out_valid=1 -> out_valid=0 and counters=0 immediately (asynchronous); in_ready=1 after release.
- Direction table: rs1=0xFFFFFFFF, rs2=0x00000001, XLEN=32, funct3 cycled 000..111 -> taken = 0,1,x,x,1,0,0,1. Codes 010/011 give illegal=1 and taken=0.
- Target/redirect with wrap:
  - pc=0xFFFFFFFC, imm=0x8, taken, pred_taken=0 -> target=0x00000004, mispredict=1, redirect=0x00000004, one cycle after capture.
  - Same with not-taken, pred_taken=1 -> redirect=0x00000000.
- Backpressure: out_ready=0 for 3 cycles with in_valid held -> in_ready=0 and outputs stable. Release gives one handshake per cycle for a 4-request burst; cnt_branches=4.
- Flush: flush=1 in the same cycle as in_valid with out_valid=1 -> next cycle out_valid=0, no capture, counters unchanged.
- Counter saturation/clear:
  - CNT_W=4, 17 mispredicted branches -> both counters = 15.
  - cnt_clear asserted coincident with a handshake -> both counters = 0.
